// File: rtl/matmul_calc_pkg.sv
// Shared definitions for the matmul APB register slave: address map, FSM states,
// register selectors and default widths.
package matmul_calc_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned MAX_DIM_DEF = 4;
  localparam int unsigned MODE_W_DEF  = 4;

  localparam int unsigned CONTROL_ADDR = 32'h00;
  localparam int unsigned OPA_BASE     = 32'h10;
  localparam int unsigned OPB_BASE     = 32'h30;
  localparam int unsigned FLAGS_ADDR   = 32'h50;
  localparam int unsigned SP_BASE      = 32'h60;

  localparam int unsigned START_BIT = 0;
  localparam int unsigned MODE_LSB  = 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_OPA,
    SEL_OPB,
    SEL_FLAGS,
    SEL_SP
  } reg_sel_t;

  // True when addr falls inside a block of 'words' consecutive 32-bit registers.
  function automatic logic in_window(input int unsigned addr, input int unsigned base,
                                     input int unsigned words);
    return (addr >= base) && (addr < base + 4 * words);
  endfunction

endpackage

// File: rtl/matmul_calc_apb_decoder.sv
// Combinational APB address decode: maps a byte address to a register selector
// and row index, and flags whether the access direction is legal.
module matmul_calc_apb_decoder
  import matmul_calc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int MAX_DIM    = MAX_DIM_DEF,
  parameter int IDX_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  pwrite_i,
  output logic                  hit_o,
  output reg_sel_t              sel_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  rw_ok_o
);

  logic [31:0] addr;

  always_comb begin
    addr  = 32'(paddr_i);
    sel_o = SEL_NONE;
    idx_o = '0;
    // Misaligned addresses never hit, whatever the upper bits say.
    if (paddr_i[1:0] == 2'b00) begin
      if (addr == CONTROL_ADDR) begin
        sel_o = SEL_CTRL;
      end else if (in_window(addr, OPA_BASE, MAX_DIM)) begin
        sel_o = SEL_OPA;
        idx_o = IDX_W'((addr - OPA_BASE) >> 2);
      end else if (in_window(addr, OPB_BASE, MAX_DIM)) begin
        sel_o = SEL_OPB;
        idx_o = IDX_W'((addr - OPB_BASE) >> 2);
      end else if (addr == FLAGS_ADDR) begin
        sel_o = SEL_FLAGS;
      end else if (in_window(addr, SP_BASE, MAX_DIM)) begin
        sel_o = SEL_SP;
        idx_o = IDX_W'((addr - SP_BASE) >> 2);
      end
    end
    hit_o   = (sel_o != SEL_NONE);
    rw_ok_o = hit_o && !(pwrite_i && ((sel_o == SEL_FLAGS) || (sel_o == SEL_SP)));
  end

endmodule

// File: rtl/matmul_calc_apb_slave.sv
// APB completer for the matmul engine: register bank, start/busy handshake and
// one-wait-state APB protocol FSM with registered pready/pslverr/prdata.
module matmul_calc_apb_slave
  import matmul_calc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int MAX_DIM    = MAX_DIM_DEF,
  parameter int MODE_WIDTH = MODE_W_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [DATA_WIDTH/8-1:0]       pstrb_i,
  input  logic [DATA_WIDTH-1:0]         pwdata_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic [DATA_WIDTH-1:0]         prdata_o,
  output logic                          busy_o,
  output logic                          start_o,
  output logic [MODE_WIDTH-1:0]         mode_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] op_a_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] op_b_o,
  input  logic [MAX_DIM*DATA_WIDTH-1:0] sp_data_i,
  input  logic [DATA_WIDTH-1:0]         flags_i,
  input  logic                          done_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam logic [DATA_WIDTH-1:0] START_MASK = DATA_WIDTH'(1) << START_BIT;

  apb_state_t            state_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  busy_q;
  logic                  start_q;
  logic [DATA_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0] flags_q;
  logic [DATA_WIDTH-1:0] opa_q [MAX_DIM];
  logic [DATA_WIDTH-1:0] opb_q [MAX_DIM];

  logic                  dec_hit;
  reg_sel_t              dec_sel;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_rw_ok;

  logic                  commit;
  logic                  acc_err;
  logic                  wr_en;
  logic                  start_req;
  logic [DATA_WIDTH-1:0] rd_data;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
    end
    return r;
  endfunction

  matmul_calc_apb_decoder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_DIM   (MAX_DIM),
    .IDX_W     (IDX_W)
  ) u_decoder (
    .paddr_i (paddr_i),
    .pwrite_i(pwrite_i),
    .hit_o   (dec_hit),
    .sel_o   (dec_sel),
    .idx_o   (dec_idx),
    .rw_ok_o (dec_rw_ok)
  );

  // The transfer is committed on the edge that moves SETUP into ACCESS.
  assign commit    = (state_q == SETUP) && psel_i && penable_i;
  assign acc_err   = !dec_hit || !dec_rw_ok || (pwrite_i && busy_q);
  assign wr_en     = commit && pwrite_i && !acc_err;
  assign start_req = wr_en && (dec_sel == SEL_CTRL) && pstrb_i[START_BIT/8] && pwdata_i[START_BIT];

  always_comb begin
    rd_data = '0;
    case (dec_sel)
      SEL_CTRL:  rd_data = ctrl_q;
      SEL_OPA:   rd_data = opa_q[dec_idx];
      SEL_OPB:   rd_data = opb_q[dec_idx];
      SEL_FLAGS: rd_data = flags_q;
      SEL_SP:    rd_data = sp_data_i[dec_idx*DATA_WIDTH +: DATA_WIDTH];
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      ctrl_q    <= '0;
      flags_q   <= '0;
      for (int i = 0; i < MAX_DIM; i++) begin
        opa_q[i] <= '0;
        opb_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE:    if (psel_i && !penable_i) state_q <= SETUP;
        SETUP:   state_q <= commit ? ACCESS : IDLE;
        ACCESS:  state_q <= (psel_i && !penable_i) ? SETUP : IDLE;
        default: state_q <= IDLE;
      endcase

      pready_q  <= commit;
      pslverr_q <= commit && acc_err;
      prdata_q  <= (commit && !pwrite_i && !acc_err) ? rd_data : '0;
      start_q   <= start_req;

      // start_req implies !busy_q, so it never collides with a done pulse.
      if (start_req) begin
        busy_q  <= 1'b1;
        flags_q <= '0;
      end else if (busy_q && done_i) begin
        busy_q  <= 1'b0;
        flags_q <= flags_i;
      end

      if (wr_en) begin
        case (dec_sel)
          SEL_CTRL: ctrl_q         <= merge_bytes(ctrl_q, pwdata_i, pstrb_i) & ~START_MASK;
          SEL_OPA:  opa_q[dec_idx] <= merge_bytes(opa_q[dec_idx], pwdata_i, pstrb_i);
          SEL_OPB:  opb_q[dec_idx] <= merge_bytes(opb_q[dec_idx], pwdata_i, pstrb_i);
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_DIM; i++) begin
      op_a_o[i*DATA_WIDTH +: DATA_WIDTH] = opa_q[i];
      op_b_o[i*DATA_WIDTH +: DATA_WIDTH] = opb_q[i];
    end
  end

  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;
  assign prdata_o  = prdata_q;
  assign busy_o    = busy_q;
  assign start_o   = start_q;
  assign mode_o    = ctrl_q[MODE_LSB +: MODE_WIDTH];

endmodule

// File: tb/tb_matmul_calc_apb_slave.sv
// Directed bench for the matmul APB slave: APB transfers push expected responses
// into a queue, a monitor pops and compares whenever pready_o is seen.
module tb_matmul_calc_apb_slave;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel, penable, pwrite;
  logic [3:0]   pstrb;
  logic [31:0]  pwdata;
  logic [15:0]  paddr;
  logic         pready, pslverr;
  logic [31:0]  prdata;
  logic         busy, start;
  logic [3:0]   mode;
  logic [127:0] op_a, op_b, sp_data;
  logic [31:0]  flags;
  logic         done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  matmul_calc_apb_slave dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .pstrb_i  (pstrb),
    .pwdata_i (pwdata),
    .paddr_i  (paddr),
    .pready_o (pready),
    .pslverr_o(pslverr),
    .prdata_o (prdata),
    .busy_o   (busy),
    .start_o  (start),
    .mode_o   (mode),
    .op_a_o   (op_a),
    .op_b_o   (op_b),
    .sp_data_i(sp_data),
    .flags_i  (flags),
    .done_i   (done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (pready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pready: got 1 expected 0");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_pslverr"}, pslverr, e.err);
          if (e.chk_data) check({e.name, "_prdata"}, prdata, e.data);
        end
      end else if (rst === 1'b0) begin
        check("idle_bus_outputs", {pslverr, prdata}, '0);
      end
    end
  end

  task automatic apb(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input bit exp_err, input logic [31:0] exp_data,
                     input string name, input bit pulse_done = 1'b0);
    int   n;
    exp_t e;
    e.name     = name;
    e.err      = exp_err;
    e.chk_data = !wr;
    e.data     = exp_err ? 32'h0 : exp_data;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    sb.push_back(e);
    if (pulse_done) done = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      done = 1'b0;
      n++;
    end while (pready !== 1'b1 && n < 8);
    if (pready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no pready expected pready within 8 cycles", name);
      if (sb.size() > 0) sb.delete(sb.size() - 1);
    end else begin
      check({name, "_latency"}, n, 1);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0; pwdata = '0;
    paddr = '0; sp_data = '0; flags = '0; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl_outs", {pready, pslverr, prdata, busy, start, mode}, '0);
    check("reset_op_a", op_a, '0);
    check("reset_op_b", op_b, '0);
    rst = 1'b0;

    apb(0, 16'h0000, 0, 4'h0, 0, 32'h0, "rd_ctrl_reset");

    apb(1, 16'h0018, 32'hDEADBEEF, 4'b0101, 0, 0, "wr_opa2_strb");
    apb(0, 16'h0018, 0, 4'h0, 0, 32'h00AD00EF, "rd_opa2");
    check("op_a_row2", op_a[2*32 +: 32], 32'h00AD00EF);
    apb(1, 16'h0030, 32'h12345678, 4'hF, 0, 0, "wr_opb0");

    apb(1, 16'h0000, 32'h0000000B, 4'hF, 0, 0, "wr_ctrl_start");
    check("start_pulse_hi", {start, busy}, 2'b11);
    check("mode_out", mode, 4'h5);
    @(posedge clk); #1;
    check("start_pulse_lo", {start, busy}, 2'b01);
    apb(0, 16'h0000, 0, 4'h0, 0, 32'h0000000A, "rd_ctrl_busy");

    apb(1, 16'h0030, 32'hFFFFFFFF, 4'hF, 1, 0, "wr_opb0_busy");
    apb(0, 16'h0030, 0, 4'h0, 0, 32'h12345678, "rd_opb0");
    check("op_b_row0", op_b[31:0], 32'h12345678);

    sp_data = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
    apb(0, 16'h0064, 0, 4'h0, 0, 32'h22220002, "rd_sp1_busy");
    apb(0, 16'h006C, 0, 4'h0, 0, 32'h44440004, "rd_sp3");

    apb(1, 16'h0052, 32'hFFFFFFFF, 4'hF, 1, 0, "wr_misaligned");
    apb(1, 16'h0050, 32'hFFFFFFFF, 4'hF, 1, 0, "wr_flags_ro");
    apb(1, 16'h0100, 32'hFFFFFFFF, 4'hF, 1, 0, "wr_unmapped");
    apb(1, 16'h0064, 32'hFFFFFFFF, 4'hF, 1, 0, "wr_sp_ro");
    apb(0, 16'h0052, 0, 4'h0, 1, 0, "rd_misaligned");
    apb(0, 16'h0100, 0, 4'h0, 1, 0, "rd_unmapped");
    apb(0, 16'h0050, 0, 4'h0, 0, 32'h0, "rd_flags_busy");

    flags = 32'h3;
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    check("busy_after_done", busy, 1'b0);
    apb(0, 16'h0050, 0, 4'h0, 0, 32'h3, "rd_flags_done");
    flags = 32'h9;
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    apb(0, 16'h0050, 0, 4'h0, 0, 32'h3, "rd_flags_idle_done");

    apb(1, 16'h0018, 32'hFFFFFFFF, 4'h0, 0, 0, "wr_opa2_nostrb");
    apb(0, 16'h0018, 0, 4'h0, 0, 32'h00AD00EF, "rd_opa2_nostrb");

    apb(1, 16'h0000, 32'h00000003, 4'hF, 0, 0, "wr_ctrl_start2");
    check("start2_pulse", {start, busy}, 2'b11);
    flags = 32'h7;
    apb(1, 16'h0000, 32'h0000001F, 4'hF, 1, 0, "wr_ctrl_start_vs_done", 1'b1);
    check("start_rejected", {start, busy}, 2'b00);
    check("mode_kept", mode, 4'h1);
    apb(0, 16'h0000, 0, 4'h0, 0, 32'h00000002, "rd_ctrl_after_reject");
    apb(0, 16'h0050, 0, 4'h0, 0, 32'h7, "rd_flags_after_reject");

    apb(1, 16'h0014, 32'hCAFE0000, 4'hF, 0, 0, "wr_opa1");
    apb(1, 16'h0000, 32'h00000003, 4'hF, 0, 0, "wr_ctrl_start3");
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0014;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_no_pready", {pready, pslverr, prdata, busy, start, mode}, '0);
    check("rst_mid_op_a", op_a, '0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    apb(0, 16'h0000, 0, 4'h0, 0, 32'h0, "rd_ctrl_after_rst");
    apb(0, 16'h0014, 0, 4'h0, 0, 32'h0, "rd_opa1_after_rst");
    apb(0, 16'h0050, 0, 4'h0, 0, 32'h0, "rd_flags_after_rst");

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
